// File: rtl/layer0_conv_sequencer_if.sv
// Engine-side bus between the stem-conv sequencer and depthwise_conv3x3_engine.
// The sequencer owns window/kernel/start/clear; the engine returns result/valid.
interface layer0_conv_sequencer_if;
  logic [8:0][7:0]    conv_window;
  logic [8:0][7:0]    conv_kernel;
  logic               conv_start;
  logic               conv_clear;
  logic signed [31:0] conv_result;
  logic               conv_valid;

  modport master (
    output conv_window, conv_kernel, conv_start, conv_clear,
    input  conv_result, conv_valid
  );

  modport slave (
    input  conv_window, conv_kernel, conv_start, conv_clear,
    output conv_result, conv_valid
  );
endinterface

// File: rtl/layer0_conv_sequencer.sv
// First-layer stem convolution sequencer: three clear/start/wait passes (R,G,B)
// per output channel through the 3x3 engine, summed into one pre-activation.
module layer0_conv_sequencer #(
  parameter int NUM_OC  = 2,
  parameter int TIMEOUT = 64,
  parameter int WA_W    = $clog2(NUM_OC*27)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pix_wr_en,
  input  logic [1:0]           pix_wr_ch,
  input  logic [4:0]           pix_wr_addr,
  input  logic [7:0]           pix_wr_data,
  input  logic                 wt_wr_en,
  input  logic [WA_W-1:0]      wt_wr_addr,
  input  logic [7:0]           wt_wr_data,
  input  logic                 start,
  input  logic [1:0]           win_row,
  input  logic [1:0]           win_col,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  layer0_conv_sequencer_if.master conv,
  output logic                 oc_valid,
  output logic [4:0]           oc_index,
  output logic signed [31:0]   oc_sum
);
  localparam int WDEPTH = NUM_OC*27;
  localparam int TW     = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_START, S_WAIT, S_ACC, S_EMIT, S_DONE
  } state_t;

  state_t             state;
  logic [7:0]         pix [75];      // flat ch*25 + row*5 + col
  logic [7:0]         wt  [WDEPTH];
  logic [1:0]         row_q, col_q, ch;
  logic [4:0]         oc;
  logic [TW-1:0]      wcnt;
  logic signed [31:0] acc, res_q, acc_nxt;
  logic [6:0]         pbase;
  logic [WA_W-1:0]    wbase;
  logic [6:0]         paddr [9];
  logic [WA_W-1:0]    waddr [9];

  // Buffers carry no reset so a run can be repeated after an abort without reloading.
  always_ff @(posedge clock) begin
    if (state == S_IDLE) begin
      if (pix_wr_en && pix_wr_ch != 2'd3 && pix_wr_addr <= 5'd24)
        pix[7'(pix_wr_ch)*7'd25 + 7'(pix_wr_addr)] <= pix_wr_data;
      if (wt_wr_en && 32'(wt_wr_addr) < WDEPTH)
        wt[wt_wr_addr] <= wt_wr_data;
    end
  end

  assign pbase   = 7'(ch)*7'd25 + 7'(row_q)*7'd5 + 7'(col_q);
  assign wbase   = WA_W'(32'(oc)*27 + 32'(ch)*9);
  assign acc_nxt = acc + res_q;

  for (genvar k = 0; k < 9; k++) begin : g_tap
    localparam int POFF = (k/3)*5 + k%3;
    assign paddr[k] = pbase + 7'(POFF);
    assign waddr[k] = wbase + WA_W'(k);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      oc_valid         <= 1'b0;
      oc_index         <= '0;
      oc_sum           <= '0;
      conv.conv_window <= '0;
      conv.conv_kernel <= '0;
      conv.conv_start  <= 1'b0;
      conv.conv_clear  <= 1'b0;
      row_q            <= '0;
      col_q            <= '0;
      ch               <= '0;
      oc               <= '0;
      wcnt             <= '0;
      acc              <= '0;
      res_q            <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          row_q <= (win_row == 2'd3) ? 2'd2 : win_row;
          col_q <= (win_col == 2'd3) ? 2'd2 : win_col;
          error <= 1'b0;
          oc    <= '0;
          ch    <= '0;
          acc   <= '0;
          busy  <= 1'b1;
          state <= S_LOAD;
        end
        S_LOAD: begin
          for (int k = 0; k < 9; k++) begin
            conv.conv_window[k] <= pix[paddr[k]];
            conv.conv_kernel[k] <= wt[waddr[k]];
          end
          conv.conv_clear <= 1'b1;
          state           <= S_CLEAR;
        end
        S_CLEAR: begin
          conv.conv_clear <= 1'b0;
          conv.conv_start <= 1'b1;
          state           <= S_START;
        end
        S_START: begin
          conv.conv_start <= 1'b0;
          wcnt            <= '0;
          state           <= S_WAIT;
        end
        S_WAIT: begin
          if (conv.conv_valid) begin
            res_q <= conv.conv_result;
            state <= S_ACC;
          end else if (wcnt == TW'(TIMEOUT-1)) begin
            // engine hung: drop this channel and end the run
            error <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_ACC: begin
          acc <= acc_nxt;
          if (ch < 2'd2) begin
            ch    <= ch + 1'b1;
            state <= S_LOAD;
          end else begin
            oc_valid <= 1'b1;
            oc_index <= oc;
            oc_sum   <= acc_nxt;
            state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          oc_valid <= 1'b0;
          acc      <= '0;
          ch       <= '0;
          if (oc == 5'(NUM_OC-1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            oc    <= oc + 1'b1;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/layer0_conv_sequencer.md
Name: layer0_conv_sequencer

Overview:
Hardware initiator for depthwise_conv3x3_engine. It runs the first-layer stem convolution that is currently driven by hand from the testbench. It holds a 5x5x3 (R,G,B) pixel patch and NUM_OC x 27 signed int8 weights. For each output channel it issues three clear/start/wait transactions, one per input colour, to the engine, sums the three partial results, and emits one 32-bit pre-activation value per output channel.

Parameters:
NUM_OC, 2, number of output channels processed per run (1..32)
TIMEOUT, 64, maximum cycles spent in WAIT before aborting with error
WA_W, $clog2(NUM_OC*27), weight write-address width (derived)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
pix_wr_en  in  1  pixel buffer write strobe
pix_wr_ch  in  2  colour plane: 0=R, 1=G, 2=B; 3 is ignored
pix_wr_addr  in  5  raster index row*5+col, 0..24; values above 24 are ignored
pix_wr_data  in  8  unsigned pixel
wt_wr_en  in  1  weight buffer write strobe
wt_wr_addr  in  WA_W  oc*27 + ch*9 + k
wt_wr_data  in  8  signed int8 weight
start  in  1  run request, single-cycle pulse
win_row  in  2  window top row, sampled on start
win_col  in  2  window left column, sampled on start
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
error  out  1  sticky timeout flag, cleared on next accepted start
conv_window  out  9x8  window_in to engine
conv_kernel  out  9x8  kernel_weights to engine
conv_start  out  1  start_conv to engine
conv_clear  out  1  clear to engine
conv_result  in  32  engine conv_result (signed)
conv_valid  in  1  engine result_valid
oc_valid  out  1  one-cycle pulse, oc_sum valid
oc_index  out  5  output channel of oc_sum
oc_sum  out  32  signed R+G+B sum

Behaviour:
- Reset: all outputs go to 0 and the FSM goes to IDLE. Pixel and weight buffers have no reset; their contents are retained.
- Buffer writes are accepted only in IDLE. Writes while busy=1 are dropped.
- start is accepted only in IDLE. On acceptance:
  - latch win_row and win_col, each saturated to 2 if the input is 3;
  - clear error, set oc=0, ch=0, set busy=1.
  - start while busy is ignored.
- Window mapping for output channel oc and input colour ch:
  - conv_window[k] = pix[ch][(row+k/3)*5 + col+k%3]
  - conv_kernel[k] = wt[oc*27 + ch*9 + k]
  - k = 0..8, row-major.
- FSM states and transitions:
  - IDLE
  - LOAD (1 cycle): register conv_window and conv_kernel.
  - CLEAR (1 cycle): conv_clear=1.
  - START (1 cycle): conv_start=1.
  - WAIT: leave when conv_valid=1 is sampled at a clock edge.
  - ACC (1 cycle): acc += conv_result. If ch<2, increment ch and go to LOAD; otherwise go to EMIT.
  - EMIT (1 cycle): oc_valid=1, oc_index=oc, oc_sum=acc. Clear acc and ch. If oc<NUM_OC-1, increment oc and go to LOAD; otherwise go to DONE.
  - DONE (1 cycle): done=1, busy=0 on the next edge, then IDLE.
- conv_window and conv_kernel stay stable from LOAD through ACC of each transaction.
- conv_start and conv_clear are never high in the same cycle.
- conv_valid is ignored outside WAIT.
- Arithmetic: acc is 32-bit two's-complement, wraps and does not saturate. It is cleared at start of each output channel.
- Cycles per transaction: 4 + W, where W is the number of WAIT cycles (at least 1). A run takes NUM_OC*(3*(4+W)+1) + 1 cycles.
- Timeout: if WAIT lasts TIMEOUT cycles without conv_valid, the block:
  - sets error=1;
  - drops the current output channel (no oc_valid);
  - goes to DONE, so done pulses and busy falls.
- Reset asserted mid-run: immediate abort, all outputs 0, no done pulse. The engine sees conv_start=0 and conv_clear=0.
- oc_sum and oc_index hold their last values between oc_valid pulses.

Test Plan:
- All pixels = 1. oc0 weights all 0x01, oc1 weights all 0xFF. Bench engine model returns the 9-tap dot product after 3 cycles. win=(1,1), start -> oc_valid twice: (0, 27) then (1, -27). done after exactly 2*(3*7+1)+1 = 45 cycles. error=0.
- R plane pix[i]=i, G and B planes = 0. oc0 weights: only R k=4 is 1, all others 0. Sweep win=(0,0), (1,1), (2,2) -> oc_sum = 6, 12, 18.
- Egypt-cat patch with the R/G/B values used in bring-up and the matching oc0/oc1 weights, win=(1,1) -> oc_sum matches the software golden model. Check every conv_clear/conv_start pair against the expected window and kernel bytes.
- Engine model never asserts valid -> error=1 and done at the 64th WAIT cycle, no oc_valid, busy=0. A following start clears error and completes normally.
- Assert reset during the WAIT of oc0 G -> busy, conv_start, conv_clear, oc_valid and done all 0 immediately. Restart without reloading the buffers -> same results as the first run.
- start and buffer writes pulsed while busy -> both ignored; results unchanged. Write with pix_wr_ch=3 -> no buffer change.
